addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the fixed 4-bit ripple-carry add/sub.
- Processes a W-bit operand pair CHUNK bits per cycle, LSB chunk first, carrying between chunks through a registered carry.
- Valid/ready handshake on input and output; reports carry-out, signed overflow and zero flags.
- Used in datapaths where a full-width carry chain would limit timing or area.

Parameters:
- W, 16, operand/result width in bits; must be an integer multiple of CHUNK, and W >= CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = W/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept an operation.
- a  input  W  operand A.
- b  input  W  operand B.
- mode  input  1  0 = A+B, 1 = A-B (A + ~B + 1).
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- res  output  W  sum/difference, modulo 2^W.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  res == 0.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, res=0, cout=0, ovf=0, zero=0. Internal chunk index and carry are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture a, b^{W{mode}} and mode; set carry=mode and index=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle add chunk[index] of A, chunk[index] of B', and carry. Write the CHUNK sum bits into res[index*CHUNK +: CHUNK] and register the carry.
  - On the last chunk (index = NCHUNK-1):
    - cout = final carry.
    - ovf = carry into MSB XOR carry out of MSB.
    - zero computed from the complete result.
    - Go to DONE.
  - Otherwise increment index.
- DONE:
  - out_valid=1.
  - res and flags are held stable while out_valid=1 and out_ready=0.
  - When out_ready is high: out_valid=0 next cycle, go to IDLE. in_ready returns 1 in the following cycle; there is no same-cycle accept/complete bypass.
- Latency: the operation is accepted on edge 0, and out_valid rises after edge NCHUNK. With defaults, out_valid is first high in the 4th cycle after the accept edge.
- Throughput: one operation per NCHUNK+2 cycles minimum.
- Output registers: res may show partial contents while in RUN. Consumers use res and flags only when out_valid=1.
- Operand sampling: a, b and mode are sampled only at the accept edge. Later changes have no effect on the operation in flight.
- in_valid while not in IDLE: ignored, and no operation is queued.
- NCHUNK=1 (W=CHUNK): RUN lasts one cycle; behaviour is otherwise identical.
- rst in any state: aborts the operation and returns all outputs to their reset values on that edge. No result is emitted for the aborted operation.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - When ovf=1, res is clamped: a[W-1]=0 -> 0111..1, a[W-1]=1 -> 1000..0. Captured a is used.
  - ovf still reports 1; cout is unchanged (unsaturated carry).
  - zero is computed from the clamped res.
  - The clamp is applied when entering DONE; latency is unchanged.
- Undefined: res is always the wrapped modulo-2^W result. No clamp logic is present.

Test Plan:
- W=16, CHUNK=4: a=0x1234, b=0x0FFF, mode=0 -> res=0x2233, cout=0, ovf=0, zero=0; out_valid first high 4 cycles after accept.
- a=0x7FFF, b=0x0001, mode=0 -> res=0x8000, ovf=1, cout=0. With ADDSUB_SATURATE_EN: res=0x7FFF, ovf=1.
- a=0x0005, b=0x0007, mode=1 -> res=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, mode=1 -> res=0x7FFF, cout=1, ovf=1; with ADDSUB_SATURATE_EN res=0x8000.
- a=0x00FF, b=0x00FF, mode=1 -> res=0x0000, zero=1, cout=1; hold out_ready=0 for 5 cycles -> out_valid, res and flags stable. in_valid pulses meanwhile are ignored (in_ready=0).
- Assert rst two cycles into RUN -> next edge out_valid=0, in_ready=1, res=0. Then a new operation 0x0001+0x0001 -> res=0x0002 with normal latency.
- Back-to-back operations with out_ready tied high -> consecutive accepts spaced NCHUNK+2 cycles apart, and every result is correct.

Source files
------------

// File: rtl/addsub_seq.sv
// Multi-cycle chunked adder/subtractor with valid/ready handshake and carry/overflow/zero flags.
// Optional build macro ADDSUB_SATURATE_EN clamps overflowing results to the signed limit.
module addsub_seq #(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NCHUNK = W / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((W % CHUNK) != 0 || W < CHUNK) begin : g_bad_params
      $error("addsub_seq: W must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx_reg;

  logic [CHUNK-1:0]   a_chunks [NCHUNK];
  logic [CHUNK-1:0]   b_chunks [NCHUNK];
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic [W-1:0]       res_next;
  logic [W-1:0]       final_res;
  logic               ovf_next;
  logic               last_chunk;

  // Per-chunk operand slices and result merge: only the active chunk is rewritten.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign res_next[gi*CHUNK +: CHUNK] =
        (idx_reg == IDX_W'(gi)) ? chunk_sum[CHUNK-1:0] : res[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign a_chunk    = a_chunks[idx_reg];
  assign b_chunk    = b_chunks[idx_reg];
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
  assign last_chunk = (idx_reg == IDX_W'(NCHUNK - 1));

  // Same-sign operands producing an opposite-sign result is exactly cin(MSB) ^ cout(MSB).
  assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (res_next[W-1] != a_reg[W-1]);

`ifdef ADDSUB_SATURATE_EN
  assign final_res = ovf_next ? {a_reg[W-1], {(W-1){~a_reg[W-1]}}} : res_next;
`else
  assign final_res = res_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b ^ {W{mode}};
            carry_reg <= mode;
            idx_reg   <= '0;
            in_ready  <= 1'b0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          res       <= res_next;
          carry_reg <= chunk_sum[CHUNK];
          if (last_chunk) begin
            res       <= final_res;
            cout      <= chunk_sum[CHUNK];
            ovf       <= ovf_next;
            zero      <= (final_res == '0);
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: integer-arithmetic reference model, queue-based monitor.
module tb_addsub_seq;
  localparam int W      = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = W / CHUNK;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         cout;
  logic         ovf;
  logic         zero;

  always #5 clk = ~clk;

  addsub_seq #(.W(W), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .cout(cout), .ovf(ovf), .zero(zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer sum/difference, then wrap, borrow and range rules.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic m);
    exp_t   e;
    longint ux, uy, s, sx, sy, exact;
    logic [63:0] s_bits;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (m) begin
      s      = ux - uy;
      exact  = sx - sy;
      e.cout = (ux >= uy);
    end else begin
      s      = ux + uy;
      exact  = sx + sy;
      e.cout = (s >= (64'sd1 <<< W));
    end
    s_bits = 64'(s);
    e.res  = s_bits[W-1:0];
    e.ovf  = (exact > ((64'sd1 <<< (W-1)) - 1)) || (exact < -(64'sd1 <<< (W-1)));
`ifdef ADDSUB_SATURATE_EN
    if (e.ovf) e.res = (exact > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    e.zero = (e.res == '0);
    e.a    = x;
    e.b    = y;
    e.mode = m;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: latency on out_valid rise, result compare on each output handshake.
  logic prev_ov = 1'b0;
  int   mon_acc;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL latency_unexpected: out_valid rose with no operation pending (cycle %0d)", cyc);
        end else begin
          mon_acc = lat_q.pop_front();
          check("latency", 64'(cyc - mon_acc), 64'(NCHUNK));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL result_unexpected: res=%h with no operation pending", res);
        end else begin
          mon_e = exp_q.pop_front();
          $display("txn a=%h b=%h mode=%0d -> res=%h cout=%0d ovf=%0d zero=%0d (exp res=%h cout=%0d ovf=%0d zero=%0d)",
                   mon_e.a, mon_e.b, mon_e.mode, res, cout, ovf, zero,
                   mon_e.res, mon_e.cout, mon_e.ovf, mon_e.zero);
          check("res", 64'(res), 64'(mon_e.res));
          check("cout", 64'(cout), 64'(mon_e.cout));
          check("ovf", 64'(ovf), 64'(mon_e.ovf));
          check("zero", 64'(zero), 64'(mon_e.zero));
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic m, output int acc);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tot_cnt++;
      $display("FAIL in_ready_timeout: in_ready=%0d required 1", in_ready);
      acc = -1;
      return;
    end
    a = x; b = y; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc = cyc;
    exp_q.push_back(model(x, y, m));
    lat_q.push_back(cyc);
    a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      out_ready = rand_ready ? 1'($urandom) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    if (exp_q.size() > 0) begin
      tot_cnt++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, prev_acc, n;
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    rst = 1'b0;

    issue(16'h1234, 16'h0FFF, 1'b0, acc); drain(0);
    issue(16'h7FFF, 16'h0001, 1'b0, acc); drain(0);
    issue(16'h0005, 16'h0007, 1'b1, acc); drain(0);
    issue(16'h8000, 16'h0001, 1'b1, acc); drain(0);

    // Result held under backpressure; in_valid pulses while busy must be ignored.
    out_ready = 1'b0;
    e = model(16'h00FF, 16'h00FF, 1'b1);
    issue(16'h00FF, 16'h00FF, 1'b1, acc);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2 == 0);
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_res", 64'(res), 64'(e.res));
      check("hold_flags", 64'({cout, ovf, zero}), 64'({e.cout, e.ovf, e.zero}));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("no_queued_op", 64'({in_ready, out_valid}), 64'b10);

    // Abort two cycles into RUN.
    issue(W'($urandom), W'($urandom), 1'($urandom), acc);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_res", 64'(res), 64'd0);
    issue(16'h0001, 16'h0001, 1'b0, acc); drain(0);

    // Back-to-back with out_ready held high: accept spacing NCHUNK+2.
    prev_acc = -1;
    for (int i = 0; i < 10; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), acc);
      if (i > 0) check("accept_spacing", 64'(acc - prev_acc), 64'(NCHUNK + 2));
      prev_acc = acc;
    end
    drain(0);

    // Random operands with random backpressure.
    for (int i = 0; i < 20; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), acc);
      drain(1);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
